// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting path: field codes, value limits,
// blink_mask bit positions and wrap-around step helpers.
package clock_pkg;

    localparam logic [1:0] FIELD_RUN  = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam logic [7:0] HOUR_MAX = 8'd23;
    localparam logic [7:0] MS_MAX   = 8'd59;

    localparam int BLINK_HOUR_SHI = 5;
    localparam int BLINK_HOUR_GE  = 4;
    localparam int BLINK_MIN_SHI  = 3;
    localparam int BLINK_MIN_GE   = 2;
    localparam int BLINK_SEC_SHI  = 1;
    localparam int BLINK_SEC_GE   = 0;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_HOUR,
        ST_SET_MIN,
        ST_SET_SEC,
        ST_APPLY
    } set_state_t;

    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max);
        return (v >= max) ? 8'd0 : v + 8'd1;
    endfunction

    // Out-of-range values snap to max so the edit register always lands back in range.
    function automatic logic [7:0] wrap_dec(input logic [7:0] v, input logic [7:0] max);
        return ((v == 8'd0) || (v > max)) ? max : v - 8'd1;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_key_edge.sv
// key_edge: 2-FF synchronizer for an active-low key plus a registered one-cycle press pulse.
module key_edge (
    input  logic clk_in,
    input  logic rst_in,
    input  logic key_n,
    output logic press
);

    logic sync_p0;
    logic sync_p1;
    logic dly_p2;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            dly_p2  <= 1'b1;
            press   <= 1'b0;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
            dly_p2  <= sync_p1;
            press   <= dly_p2 & ~sync_p1;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: key-driven edit of hh:mm:ss, counter hold, load strobe and blink mask.
// Define SET_TIMEOUT_EN to abandon an edit after TIMEOUT_S idle seconds.
module clock_set_ctrl #(
    parameter int CLK_HZ    = 12_000_000,
    parameter int BLINK_HZ  = 2,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       key_mode_n,
    input  logic       key_up_n,
    input  logic       key_down_n,
    input  logic       tick_1hz,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic       run_en,
    output logic       load,
    output logic [7:0] load_hour,
    output logic [7:0] load_min,
    output logic [7:0] load_sec,
    output logic [1:0] edit_field,
    output logic [5:0] blink_mask
);
    import clock_pkg::*;

    localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    set_state_t state, state_nxt;
    logic mode_p, up_p, down_p, any_press;
    logic in_set, enter_set, adj_up, adj_dn, timeout;
    logic [7:0] hour_q, min_q, sec_q;
    logic [CNT_W-1:0] blink_cnt;
    logic blink_phase;

    key_edge u_key_mode (.clk_in(clk_in), .rst_in(rst_in), .key_n(key_mode_n), .press(mode_p));
    key_edge u_key_up   (.clk_in(clk_in), .rst_in(rst_in), .key_n(key_up_n),   .press(up_p));
    key_edge u_key_down (.clk_in(clk_in), .rst_in(rst_in), .key_n(key_down_n), .press(down_p));

    assign any_press = mode_p | up_p | down_p;
    assign in_set    = (state == ST_SET_HOUR) || (state == ST_SET_MIN) || (state == ST_SET_SEC);
    // Mode always wins; up and down together cancel each other.
    assign adj_up    = in_set && !mode_p && up_p && !down_p;
    assign adj_dn    = in_set && !mode_p && down_p && !up_p;
    assign enter_set = (state_nxt != state) &&
                       (state_nxt inside {ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC});

`ifdef SET_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_S);
    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in || !in_set || any_press) begin
            idle_cnt <= '0;
        end else if (tick_1hz && (idle_cnt != IDLE_LIMIT)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout = in_set && !any_press && (idle_cnt == IDLE_LIMIT);
`else
    logic unused_tick;
    assign unused_tick = tick_1hz & (TIMEOUT_S > 0);
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:      if (mode_p) state_nxt = ST_SET_HOUR;
            ST_SET_HOUR: if (mode_p) state_nxt = ST_SET_MIN; else if (timeout) state_nxt = ST_RUN;
            ST_SET_MIN:  if (mode_p) state_nxt = ST_SET_SEC; else if (timeout) state_nxt = ST_RUN;
            ST_SET_SEC:  if (mode_p) state_nxt = ST_APPLY;   else if (timeout) state_nxt = ST_RUN;
            default:     state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hour_q <= '0;
            min_q  <= '0;
            sec_q  <= '0;
        end else if ((state == ST_RUN) && mode_p) begin
            hour_q <= cur_hour;
            min_q  <= cur_min;
            sec_q  <= cur_sec;
        end else if (adj_up || adj_dn) begin
            case (state)
                ST_SET_HOUR: hour_q <= adj_up ? wrap_inc(hour_q, HOUR_MAX) : wrap_dec(hour_q, HOUR_MAX);
                ST_SET_MIN:  min_q  <= adj_up ? wrap_inc(min_q, MS_MAX)    : wrap_dec(min_q, MS_MAX);
                ST_SET_SEC:  sec_q  <= adj_up ? wrap_inc(sec_q, MS_MAX)    : wrap_dec(sec_q, MS_MAX);
                default: ;
            endcase
        end
    end

    // Blink restarts dark on every field change so the new field is visibly selected.
    always_ff @(posedge clk_in) begin
        if (rst_in || enter_set) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == HALF_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    assign run_en    = (state == ST_RUN);
    assign load      = (state == ST_APPLY);
    assign load_hour = hour_q;
    assign load_min  = min_q;
    assign load_sec  = sec_q;

    always_comb begin
        edit_field = FIELD_RUN;
        blink_mask = '0;
        case (state)
            ST_SET_HOUR: begin
                edit_field                 = FIELD_HOUR;
                blink_mask[BLINK_HOUR_SHI] = blink_phase;
                blink_mask[BLINK_HOUR_GE]  = blink_phase;
            end
            ST_SET_MIN: begin
                edit_field                 = FIELD_MIN;
                blink_mask[BLINK_MIN_SHI]  = blink_phase;
                blink_mask[BLINK_MIN_GE]   = blink_phase;
            end
            ST_SET_SEC: begin
                edit_field                 = FIELD_SEC;
                blink_mask[BLINK_SEC_SHI]  = blink_phase;
                blink_mask[BLINK_SEC_GE]   = blink_phase;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed key sequences against a behavioural edit model.
module tb_clock_set_ctrl;

    localparam int CLK_HZ    = 8;
    localparam int BLINK_HZ  = 1;
    localparam int TIMEOUT_S = 3;
    localparam int HALF      = CLK_HZ / (2 * BLINK_HZ);
    localparam int EV_N      = 2048;
`ifdef SET_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       key_mode_n = 1'b1, key_up_n = 1'b1, key_down_n = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [7:0] cur_hour = 8'd0, cur_min = 8'd0, cur_sec = 8'd0;
    logic       run_en, load;
    logic [7:0] load_hour, load_min, load_sec;
    logic [1:0] edit_field;
    logic [5:0] blink_mask;

    clock_set_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .TIMEOUT_S(TIMEOUT_S)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .key_mode_n(key_mode_n), .key_up_n(key_up_n), .key_down_n(key_down_n),
        .tick_1hz(tick_1hz),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .run_en(run_en), .load(load),
        .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
        .edit_field(edit_field), .blink_mask(blink_mask)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    logic [2:0] ev [0:EV_N-1] = '{default: 3'b000};   // {mode, up, down} acted on at edge cyc
    int lh[$], lm[$], ls[$];

    // Model: m_st 0 run, 1 hour, 2 min, 3 sec, 4 apply; m_k = edges since last field entry.
    int m_st = 0, m_h = 0, m_m = 0, m_s = 0, m_k = 0, m_idle = 0;

    function automatic int step(input int v, input int lim, input int d);
        return (v + lim + d) % lim;
    endfunction

    function automatic int exp_field(input int st);
        return (st >= 1 && st <= 3) ? st : 0;
    endfunction

    function automatic logic [5:0] exp_mask(input int st, input int k);
        logic ph;
        ph = ((k / HALF) % 2) == 1;
        case (st)
            1: return {ph, ph, 4'b0000};
            2: return {2'b00, ph, ph, 2'b00};
            3: return {4'b0000, ph, ph};
            default: return 6'b000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (rst_in) begin
            m_st <= 0; m_h <= 0; m_m <= 0; m_s <= 0; m_k <= 0; m_idle <= 0;
        end else begin
            m_k <= m_k + 1;
            case (m_st)
                0: if (ev[cyc][2]) begin
                    m_st <= 1; m_h <= cur_hour; m_m <= cur_min; m_s <= cur_sec;
                    m_k <= 0; m_idle <= 0;
                end
                1, 2, 3: begin
                    if (ev[cyc][2]) begin
                        m_st <= m_st + 1; m_k <= 0; m_idle <= 0;
                    end else if (TIMEOUT_ON && m_idle == TIMEOUT_S && ev[cyc] == 3'b000) begin
                        m_st <= 0; m_idle <= 0;
                    end else begin
                        if (ev[cyc] != 3'b000) m_idle <= 0;
                        else if (tick_1hz) m_idle <= m_idle + 1;
                        if (ev[cyc][1] != ev[cyc][0]) begin
                            if (m_st == 1) m_h <= step(m_h, 24, ev[cyc][1] ? 1 : -1);
                            if (m_st == 2) m_m <= step(m_m, 60, ev[cyc][1] ? 1 : -1);
                            if (m_st == 3) m_s <= step(m_s, 60, ev[cyc][1] ? 1 : -1);
                        end
                    end
                end
                default: m_st <= 0;
            endcase
        end
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("run_en", run_en, m_st == 0);
            chk("load", load, m_st == 4);
            chk("load_hour", load_hour, m_h);
            chk("load_min", load_min, m_m);
            chk("load_sec", load_sec, m_s);
            chk("edit_field", edit_field, exp_field(m_st));
            chk("blink_mask", blink_mask, exp_mask(m_st, m_k));
            if (load === 1'b1) begin
                lh.push_back(load_hour); lm.push_back(load_min); ls.push_back(load_sec);
            end
        end
    end

    // mask = {mode, up, down}; key held two cycles, then released for gap cycles.
    task automatic press(input logic [2:0] mask, input int gap);
        @(negedge clk_in);
        if (cyc + 3 < EV_N) ev[cyc + 3] = ev[cyc + 3] | mask;
        key_mode_n = ~mask[2]; key_up_n = ~mask[1]; key_down_n = ~mask[0];
        repeat (2) @(negedge clk_in);
        key_mode_n = 1'b1; key_up_n = 1'b1; key_down_n = 1'b1;
        repeat (gap) @(negedge clk_in);
    endtask

    task automatic wait_field(input logic [1:0] f);
        int n;
        n = 0;
        while (edit_field !== f && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        chk("wait_field", edit_field, f);
    endtask

    task automatic give_tick();
        @(negedge clk_in);
        tick_1hz = 1'b1;
        @(negedge clk_in);
        tick_1hz = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    initial begin
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        chk_en = 1'b1;
        rst_in = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("idle_run_en", run_en, 1);
        chk("idle_load", load, 0);
        chk("idle_blink", blink_mask, 0);
        chk("idle_field", edit_field, 0);

        // 12:34:56 -> hour +2, min -1 -> load 14:33:56
        cur_hour = 8'd12; cur_min = 8'd34; cur_sec = 8'd56;
        press(3'b100, 4);
        chk("capture_run_en", run_en, 0);
        press(3'b010, 4);
        press(3'b010, 4);
        press(3'b100, 4);
        press(3'b001, 4);
        press(3'b100, 4);
        press(3'b100, 4);
        chk("main_load_cnt", lh.size(), 1);
        if (lh.size() >= 1) begin
            chk("main_load_h", lh[0], 14);
            chk("main_load_m", lm[0], 33);
            chk("main_load_s", ls[0], 56);
        end

        // wrap at both ends of each range
        cur_hour = 8'd23; cur_min = 8'd59; cur_sec = 8'd0;
        press(3'b100, 4);
        press(3'b010, 4);
        chk("hour_23_up", load_hour, 0);
        press(3'b001, 4);
        chk("hour_0_down", load_hour, 23);
        press(3'b100, 4);
        press(3'b010, 4);
        chk("min_59_up", load_min, 0);
        press(3'b100, 4);
        press(3'b001, 4);
        chk("sec_0_down", load_sec, 59);
        press(3'b100, 4);
        chk("wrap_load_cnt", lh.size(), 2);
        if (lh.size() >= 2) begin
            chk("wrap_load_h", lh[1], 23);
            chk("wrap_load_m", lm[1], 0);
            chk("wrap_load_s", ls[1], 59);
        end

        // simultaneous presses
        cur_hour = 8'd5; cur_min = 8'd6; cur_sec = 8'd7;
        press(3'b100, 4);
        press(3'b011, 4);
        chk("updown_hour", load_hour, 5);
        chk("updown_field", edit_field, 1);
        press(3'b110, 4);
        chk("modeup_field", edit_field, 2);
        chk("modeup_hour", load_hour, 5);
        chk("modeup_min", load_min, 6);

        // reset while in SET_MIN
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rst_run_en", run_en, 1);
        chk("rst_load", load, 0);
        chk("rst_load_min", load_min, 0);
        chk("rst_field", edit_field, 0);
        chk("rst_blink", blink_mask, 0);
        rst_in = 1'b0;
        repeat (4) @(negedge clk_in);
        chk("rst_load_cnt", lh.size(), 2);

        // blink phase, then idle ticks
        cur_hour = 8'd1; cur_min = 8'd2; cur_sec = 8'd3;
        press(3'b100, 0);
        wait_field(2'd1);
        chk("blink_dark", blink_mask, 6'b000000);
        repeat (HALF) @(negedge clk_in);
        chk("blink_lit", blink_mask, 6'b110000);
        repeat (TIMEOUT_S) give_tick();
        repeat (4) @(negedge clk_in);
`ifdef SET_TIMEOUT_EN
        chk("timeout_field", edit_field, 0);
        chk("timeout_run_en", run_en, 1);
`else
        chk("no_timeout_field", edit_field, 1);
        chk("no_timeout_run_en", run_en, 0);
`endif
        chk("final_load_cnt", lh.size(), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the digital clock. It sequences the user edit of hours, minutes and seconds from three keys, stops the time counter during an edit, and issues a single load strobe with the edited values. It also drives the digit blink mask consumed by the 74HC595 display driver. It sits between the board keys, the 1 Hz time counter and the display driver.

## Interface
Parameters:
- CLK_HZ, 12_000_000: clk_in frequency in Hz.
- BLINK_HZ, 2: blink toggle rate. The half-period is CLK_HZ/(2*BLINK_HZ) cycles.
- TIMEOUT_S, 10: idle seconds before an edit is abandoned. Used only with SET_TIMEOUT_EN.

Ports:
- clk_in, in, 1: system clock. Single clock domain.
- rst_in, in, 1: synchronous, active-high reset.
- key_mode_n, in, 1: mode key, active-low, debounced upstream, asynchronous to clk_in.
- key_up_n, in, 1: increment key, active-low, same conditions.
- key_down_n, in, 1: decrement key, active-low, same conditions.
- tick_1hz, in, 1: one-cycle pulse per second from the divider.
- cur_hour, in, 8: live hour in binary, 0..23.
- cur_min, in, 8: live minute in binary, 0..59.
- cur_sec, in, 8: live second in binary, 0..59.
- run_en, out, 1: time counter count enable.
- load, out, 1: one-cycle strobe. The counter copies load_* on this cycle.
- load_hour, out, 8: value to load into hours.
- load_min, out, 8: value to load into minutes.
- load_sec, out, 8: value to load into seconds.
- edit_field, out, 2: current field. 0 RUN, 1 HOUR, 2 MIN, 3 SEC.
- blink_mask, out, 6: blank-request per digit, ordered {hour_shi, hour_ge, min_shi, min_ge, sec_shi, sec_ge}.

## Operation
- Each key passes through a 2-FF synchronizer and a falling-edge detector. A press is a one-cycle pulse. A held key produces one pulse only.
- FSM states are RUN, SET_HOUR, SET_MIN, SET_SEC and APPLY.
- In RUN, a mode press copies cur_hour, cur_min and cur_sec into the edit registers and moves to SET_HOUR. Up and down presses are ignored in RUN.
- Mode presses step SET_HOUR to SET_MIN, SET_MIN to SET_SEC, and SET_SEC to APPLY.
- APPLY lasts exactly one cycle: load=1, then the FSM returns to RUN.
- run_en=1 in RUN only. It is 0 in SET_* and in APPLY.
- load_* always equal the edit registers.
- In SET_* state:
  - An up press increments the active field with wrap: hour 23 to 0, min/sec 59 to 0.
  - A down press decrements the active field with wrap: 0 to 23 for hour, 0 to 59 for min/sec.
  - The other two fields do not change.
- Simultaneous press events in the same cycle:
  - up and down together: both ignored.
  - mode together with up or down: mode acts, up/down are ignored.
- Blink:
  - blink_phase toggles every CLK_HZ/(2*BLINK_HZ) cycles. It is cleared to 0 on entry to any SET_* state.
  - blink_mask sets the two digit bits of the active field to blink_phase. All other bits are 0.
  - blink_mask is all 0 in RUN and in APPLY.
- All arithmetic is 8-bit unsigned. Edit values never leave their legal range.

## Timing
- Reset values: run_en=1, load=0, load_*=0, edit_field=0, blink_mask=0, FSM=RUN, blink counter=0.
- Key press latency: a key low from edge N produces the action on the edge N+3. That is 2 synchronizer stages plus 1 edge register.
- Capture: the edit registers take cur_* on the same edge that enters SET_HOUR.
- load is high for exactly one cycle, one cycle after the SET_SEC mode press is acted on. run_en returns to 1 on the following edge.
- tick_1hz has no effect on the FSM or edit registers, except through the timeout counter.
- A reset asserted mid-edit returns to RUN with no load pulse. The edit is discarded.

## Configuration
- SET_TIMEOUT_EN defined:
  - An idle counter counts tick_1hz pulses in SET_* states. It clears on any key press and on entry to SET_HOUR.
  - When it reaches TIMEOUT_S, the FSM returns to RUN with no load pulse and run_en=1.
- SET_TIMEOUT_EN undefined: no timeout logic. An edit persists indefinitely until completed by the mode key or cleared by reset.

## Structure
- Shared package clock_pkg holds:
  - edit_field state encodings: RUN=0, HOUR=1, MIN=2, SEC=3.
  - limits HOUR_MAX=23 and MS_MAX=59.
  - blink_mask bit positions.
- Sub-module key_edge: a 2-FF synchronizer with a falling-edge pulse output. It is instantiated three times.

## Test plan
- Reset, then idle: run_en=1, load=0, blink_mask=0, edit_field=0.
- Set cur=12:34:56. Press mode, up ×2, mode, down, mode, mode. Expect:
  - one load pulse with 14:33:56;
  - run_en low from capture through APPLY.
- Wrap check:
  - hour=23 plus up gives 0; hour=0 plus down gives 23.
  - min=59 plus up gives 0; sec=0 plus down gives 59.
- Press up and down in the same cycle: value unchanged. Press mode and up in the same cycle: field advances and the value is unchanged.
- Assert reset while in SET_MIN: no load pulse; outputs return to reset values on the next edge.
- With SET_TIMEOUT_EN and TIMEOUT_S=3: enter SET_HOUR, then give 3 tick_1hz pulses with no keys. Expect RUN, no load pulse, and run_en=1.
